// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// The arbiter connects through the slave modport; a requester/memory model uses master.
interface dmem_arbiter_if;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] dmem_araddr, dmem_rdata, dmem_awaddr, dmem_wdata;
  logic        dmem_awvalid, owner, busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  dmem_rdata,
    output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    output dmem_araddr, dmem_awaddr, dmem_wdata, dmem_awvalid, owner, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output dmem_rdata,
    input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    input  dmem_araddr, dmem_awaddr, dmem_wdata, dmem_awvalid, owner, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the synchronous-read data memory port.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise M0 has fixed priority.
module dmem_arbiter #(
  parameter int DMEM_SIZE = 16384,
  parameter int LOCK_MAX  = 16
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [2:0]    state;
  logic          owner, err_q, lock_pend;
  logic [31:0]   addr_q, wdata_q, araddr_q, m0_rdata_q, m1_rdata_q;
  logic [CW-1:0] lock_cnt;
`ifdef DMEM_ARB_RR_EN
  logic          rr_last;
`endif

  logic        lock_win, any_req, win, win_we, addr_bad;
  logic [31:0] win_addr, win_wdata;

  // A pending lock overrides tie-breaking until it has been used LOCK_MAX times.
  always_comb begin
    lock_win = lock_pend && bus.m1_req && (32'(lock_cnt) < 32'(LOCK_MAX));
    any_req  = bus.m0_req || bus.m1_req;
    win      = bus.m1_req;
    if (lock_win) begin
      win = 1'b1;
    end else if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
      win = ~rr_last;
`else
      win = 1'b0;
`endif
    end
    win_we    = win ? bus.m1_we    : bus.m0_we;
    win_addr  = win ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    addr_bad  = (win_addr >= 32'(DMEM_SIZE)) || (win_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      err_q      <= 1'b0;
      lock_pend  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      lock_cnt   <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= win;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            err_q    <= addr_bad;
            lock_cnt <= lock_win ? lock_cnt + CW'(1) : '0;
`ifdef DMEM_ARB_RR_EN
            rr_last  <= win;
`endif
            // ARADDR only moves for a real read, so rejected requests leave it alone.
            if (addr_bad) begin
              state <= RESP;
            end else if (win_we) begin
              state <= WR;
            end else begin
              state    <= RD_ADDR;
              araddr_q <= win_addr;
            end
          end
        end
        WR:      state <= RESP;
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          if (owner) m1_rdata_q <= bus.dmem_rdata;
          else       m0_rdata_q <= bus.dmem_rdata;
          state <= RESP;
        end
        RESP: begin
          lock_pend <= owner && bus.m1_lock;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobe combinationally so an in-flight write never lands.
  assign bus.dmem_awvalid = (state == WR) && !rst;
  assign bus.dmem_awaddr  = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_araddr  = araddr_q;
  assign bus.m0_ack       = (state == RESP) && !owner;
  assign bus.m1_ack       = (state == RESP) && owner;
  assign bus.m0_err       = bus.m0_ack && err_q;
  assign bus.m1_err       = bus.m1_ack && err_q;
  assign bus.m0_rdata     = m0_rdata_q;
  assign bus.m1_rdata     = m1_rdata_q;
  assign bus.owner        = owner;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a completion scoreboard and a word memory model.
// Unwritten memory words read back as a fixed address-derived pattern.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DMEM_SIZE(16384), .LOCK_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          master;
    bit          err;
    bit          is_read;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  bit [31:0] mem     [0:4095];
  bit        written [0:4095];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (bus.dmem_awvalid) begin
      mem[bus.dmem_awaddr[13:2]]     <= bus.dmem_wdata;
      written[bus.dmem_awaddr[13:2]] <= 1'b1;
    end
    bus.dmem_rdata <= written[bus.dmem_araddr[13:2]] ? mem[bus.dmem_araddr[13:2]]
                                                     : pat(bus.dmem_araddr);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit m, input bit e, input bit r, input logic [31:0] d);
    exp_t x;
    x.master = m; x.err = e; x.is_read = r; x.rdata = d;
    sb.push_back(x);
  endtask

  task automatic apply_stimulus(input bit m, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    if (m) begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end
  endtask

  task automatic next_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) got++;
    end
    check_output("ack_count", 32'(got), 32'(n));
  endtask

  // Every completion pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m0_ack || bus.m1_ack) begin
      check_output("ack_onehot", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_ack: observed m0_ack=%b m1_ack=%b expected no ack",
               bus.m0_ack, bus.m1_ack);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output("ack_master", 32'(bus.m1_ack), 32'(e.master));
        check_output("ack_err", 32'(bus.m1_ack ? bus.m1_err : bus.m0_err), 32'(e.err));
        check_output("nonowner_err", 32'(bus.m1_ack ? bus.m0_err : bus.m1_err), 32'd0);
        if (e.is_read && !e.err)
          check_output("ack_rdata", bus.m1_ack ? bus.m1_rdata : bus.m0_rdata, e.rdata);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.m1_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_awvalid", 32'(bus.dmem_awvalid), 32'd0);
    check_output("rst_m0_rdata", bus.m0_rdata, 32'd0);
    check_output("rst_araddr", bus.dmem_araddr, 32'd0);

    // M0 write then read back at 0x100
    next_pos();
    apply_stimulus(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    push_exp(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check_output("wr_c0_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_output("wr_c1_awvalid", 32'(bus.dmem_awvalid), 32'd1);
    check_output("wr_c1_awaddr", bus.dmem_awaddr, 32'h100);
    check_output("wr_c1_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("wr_c2_ack", 32'(bus.m0_ack), 32'd1);
    next_pos();
    apply_stimulus(1'b0, 1'b0, 32'h100, 32'd0);
    push_exp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    check_output("rd_c1_araddr", bus.dmem_araddr, 32'h100);
    @(negedge clk);
    check_output("rd_c2_ack", 32'(bus.m0_ack), 32'd0);
    @(negedge clk);
    check_output("rd_c3_ack", 32'(bus.m0_ack), 32'd1);
    check_output("rd_c3_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    check_output("rd_c3_err", 32'(bus.m0_err), 32'd0);
    next_pos();
    bus.m0_req = 1'b0;

    // M1 out-of-range read is rejected in cycle 1
    apply_stimulus(1'b1, 1'b0, 32'h4000, 32'd0);
    push_exp(1'b1, 1'b1, 1'b1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("oor_ack", 32'(bus.m1_ack), 32'd1);
    check_output("oor_err", 32'(bus.m1_err), 32'd1);
    check_output("oor_araddr", bus.dmem_araddr, 32'h100);
    check_output("oor_m1_rdata", bus.m1_rdata, 32'd0);
    next_pos();
    bus.m1_req = 1'b0;

    // M0 misaligned write never strobes memory
    apply_stimulus(1'b0, 1'b1, 32'h102, 32'h1234_5678);
    push_exp(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check_output("mis_c0_awvalid", 32'(bus.dmem_awvalid), 32'd0);
    @(negedge clk);
    check_output("mis_c1_awvalid", 32'(bus.dmem_awvalid), 32'd0);
    check_output("mis_c1_err", 32'(bus.m0_err), 32'd1);
    check_output("mis_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    next_pos();
    bus.m0_req = 1'b0;

    // Reset during the WR cycle
    apply_stimulus(1'b0, 1'b1, 32'h200, 32'hCAFE_0001);
    next_pos();
    rst = 1'b1;
    bus.m0_req = 1'b0;
    @(negedge clk);
    check_output("rstwr_awvalid", 32'(bus.dmem_awvalid), 32'd0);
    check_output("rstwr_ack", 32'(bus.m0_ack), 32'd0);
    next_pos();
    rst = 1'b0;
    @(negedge clk);
    check_output("rstwr_busy", 32'(bus.busy), 32'd0);
    check_output("rstwr_m0_rdata", bus.m0_rdata, 32'd0);
    check_output("rstwr_awaddr", bus.dmem_awaddr, 32'd0);
    check_output("rstwr_wdata", bus.dmem_wdata, 32'd0);
    check_output("rstwr_araddr", bus.dmem_araddr, 32'd0);
    check_output("rstwr_owner", 32'(bus.owner), 32'd0);
    check_output("rstwr_not_written", 32'(written[32'h200 >> 2]), 32'd0);

    // Reset during RD_DATA leaves the read register at 0
    next_pos();
    apply_stimulus(1'b1, 1'b0, 32'h4, 32'd0);
    next_pos();
    next_pos();
    rst = 1'b1;
    bus.m1_req = 1'b0;
    next_pos();
    rst = 1'b0;
    @(negedge clk);
    check_output("rstrd_m1_rdata", bus.m1_rdata, 32'd0);
    check_output("rstrd_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);

    // Contention: continuous reads from both masters
    next_pos();
`ifdef DMEM_ARB_RR_EN
    push_exp(1'b0, 1'b0, 1'b1, pat(32'h0));
    push_exp(1'b1, 1'b0, 1'b1, pat(32'h4));
    push_exp(1'b0, 1'b0, 1'b1, pat(32'h0));
    push_exp(1'b1, 1'b0, 1'b1, pat(32'h4));
`else
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 1'b1, pat(32'h0));
`endif
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h4, 32'd0);
    wait_acks(4, 60);
    next_pos();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (2) @(negedge clk);

    // Lock: one initial plus LOCK_MAX locked M1 grants, then M0
    next_pos();
    bus.m1_lock = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'h4, 32'd0);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 1'b1, pat(32'h4));
    push_exp(1'b0, 1'b0, 1'b1, pat(32'h0));
    next_pos();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'd0);
    wait_acks(4, 60);
    next_pos();
    bus.m0_req  = 1'b0;
    bus.m1_req  = 1'b0;
    bus.m1_lock = 1'b0;
    repeat (3) @(negedge clk);
    check_output("end_busy", 32'(bus.busy), 32'd0);
    check_output("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
